uart_tx_fsm: RTL and testbench
==============================

UART_TX_FSM -- requirements
Module: uart_tx_fsm

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the number of data bits per frame, LSB first.
REQ-002 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port P_DATA  input  DATA_WIDTH  parallel byte to transmit, sampled when Data_Valid is accepted.
REQ-005 SHALL have port Data_Valid  input  1  transmit request, accepted only in IDLE.
REQ-006 SHALL have port PAR_EN  input  1  parity bit enable, sampled with P_DATA.
REQ-007 SHALL have port PAR_TYP  input  1  parity type: 0 = even, 1 = odd; sampled with P_DATA.
REQ-008 SHALL have port Ser_Data  input  1  serial data bit from the downstream-fed serializer (registered OUT_S).
REQ-009 SHALL have port Ser_En  output  1  serializer load strobe.
REQ-010 SHALL have port Ser_Send  output  1  serializer shift enable.
REQ-011 SHALL have port TX_OUT  output  1  UART line; idle high.
REQ-012 SHALL have port Busy  output  1  high while a frame is in progress.

Function
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-014 In IDLE: TX_OUT=1, Busy=0, Ser_Send=0; Ser_En = Data_Valid (combinational).
REQ-015 IDLE with Data_Valid=1 SHALL capture P_DATA, PAR_EN and PAR_TYP, and SHALL move to START on the same edge.
REQ-016 START SHALL last 1 cycle: TX_OUT=0, Ser_Send=1, bit counter cleared; next state is DATA.
REQ-017 DATA SHALL last exactly DATA_WIDTH cycles, counted by a bit counter running 0..DATA_WIDTH-1.
REQ-018 In DATA, TX_OUT SHALL equal Ser_Data.
REQ-019 In DATA, Ser_Send=1 for counts 0..DATA_WIDTH-2 and Ser_Send=0 on the last count.
REQ-020 Ser_Send is therefore high for exactly DATA_WIDTH consecutive cycles per frame.
REQ-021 After the last DATA cycle, the next state SHALL be PARITY if the captured PAR_EN=1, otherwise STOP.
REQ-022 PARITY SHALL last 1 cycle: TX_OUT = XOR of the captured data, inverted when the captured PAR_TYP=1.
REQ-023 STOP SHALL last 1 cycle: TX_OUT=1; next state is IDLE.
REQ-024 Data_Valid SHALL be ignored outside IDLE; no queuing.
REQ-025 Minimum spacing between accepted requests SHALL be one full frame plus one IDLE cycle.
REQ-026 Busy SHALL be 1 in START, DATA, PARITY and STOP.
REQ-027 Changes of P_DATA, PAR_EN or PAR_TYP mid-frame SHALL have no effect on the frame in progress.
REQ-028 Frame length SHALL be DATA_WIDTH+3 cycles with parity and DATA_WIDTH+2 without.
REQ-029 All outputs SHALL be decoded from state plus registered bits; the only combinational input path is Data_Valid to Ser_En in IDLE.

Reset
REQ-030 RST=1 SHALL asynchronously force IDLE, clear the bit counter and clear the captured data and parity settings.
REQ-031 While RST=1: TX_OUT=1, Busy=0, Ser_En=0, Ser_Send=0.
REQ-032 Reset mid-frame SHALL abort the frame; the line returns high immediately with no partial stop bit.
REQ-033 The first request SHALL be accepted on the first rising edge after RST deasserts.

Configuration
REQ-034 With macro UART_TX_PARITY_EN defined: PARITY state, PAR_EN and PAR_TYP SHALL behave as above.
REQ-035 Without UART_TX_PARITY_EN:
- PARITY state and parity logic SHALL be absent.
- PAR_EN and PAR_TYP SHALL remain as ports but be ignored.
- DATA SHALL always proceed to STOP.

Structure
REQ-036 State encoding (3-bit) and the START, STOP and IDLE line-level constants SHALL live in shared package uart_tx_pkg.
REQ-037 Parity generation SHALL be sub-module parity_calc:
- inputs: captured data, PAR_TYP;
- output: parity bit;
- instantiated only when UART_TX_PARITY_EN is defined.

Verification
REQ-038 Reset then idle 5 cycles -> TX_OUT=1, Busy=0, Ser_En=0, Ser_Send=0 throughout.
REQ-039 P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, with the serializer model attached:
- TX_OUT = 0, then 1,0,1,0,0,1,0,1, then parity 0, then stop 1;
- Busy high for 11 cycles;
- Ser_Send high for 8 cycles.
REQ-040 P_DATA=0x01, PAR_EN=1, PAR_TYP=1 -> parity bit 0.
REQ-041 P_DATA=0x01, PAR_EN=0 -> frame of 10 cycles with no parity bit; the STOP cycle directly follows data bit 7.
REQ-042 Data_Valid pulsed during DATA with P_DATA=0xFF -> current frame unchanged; no second frame starts.
REQ-043 RST asserted during data bit 3 -> TX_OUT=1 and Busy=0 within the same cycle; a new 0x3C request after release transmits correctly.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared state encoding and line-level constants for the UART transmit FSM.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam logic LINE_IDLE  = 1'b1;
   localparam logic LINE_START = 1'b0;
   localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/parity_calc.sv
// Parity bit generator: XOR of the data word, inverted for odd parity.
module parity_calc #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  par_typ,
   output logic                  parity
);

   assign parity = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit sequencer driving an external serializer, one bit per CLK.
// Optional parity bit enabled with macro UART_TX_PARITY_EN.
//
// state  | meaning
// IDLE   | line high, waiting for Data_Valid
// START  | start bit (low), first serializer shift
// DATA   | DATA_WIDTH data bits taken from Ser_Data, LSB first
// PARITY | parity bit of the captured word
// STOP   | stop bit (high), then back to IDLE
module uart_tx_fsm
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  Ser_Data,
   output logic                  Ser_En,
   output logic                  Ser_Send,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

   tx_state_t             state;
   logic [CNT_W-1:0]      bit_cnt;
   logic [DATA_WIDTH-1:0] data_q;

`ifdef UART_TX_PARITY_EN
   logic par_en_q;
   logic par_typ_q;
   logic parity_bit;

   parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity_calc (
      .data    (data_q),
      .par_typ (par_typ_q),
      .parity  (parity_bit)
   );
`else
   // Parity inputs and the captured word have no consumer in this build.
   logic unused_cfg;
   assign unused_cfg = ^{data_q, PAR_EN, PAR_TYP};
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         data_q   <= '0;
         Busy     <= 1'b0;
         Ser_Send <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (Data_Valid) begin
                  data_q   <= P_DATA;
`ifdef UART_TX_PARITY_EN
                  par_en_q  <= PAR_EN;
                  par_typ_q <= PAR_TYP;
`endif
                  state    <= START;
                  Busy     <= 1'b1;
                  Ser_Send <= 1'b1;
               end
            end
            START: begin
               bit_cnt  <= '0;
               state    <= DATA;
               Ser_Send <= (LAST_CNT != '0);
            end
            DATA: begin
               if (bit_cnt == LAST_CNT) begin
                  Ser_Send <= 1'b0;
`ifdef UART_TX_PARITY_EN
                  state    <= par_en_q ? PARITY : STOP;
`else
                  state    <= STOP;
`endif
               end else begin
                  bit_cnt  <= bit_cnt + 1'b1;
                  // Drop the shift strobe one cycle early: the last bit is already on Ser_Data.
                  Ser_Send <= (bit_cnt != LAST_CNT - 1'b1);
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               state <= STOP;
            end
`endif
            STOP: begin
               state <= IDLE;
               Busy  <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               Busy     <= 1'b0;
               Ser_Send <= 1'b0;
            end
         endcase
      end
   end

   // Gated by RST so a request held during reset never strobes the serializer.
   assign Ser_En = (state == IDLE) && Data_Valid && !RST;

   always_comb begin
      TX_OUT = LINE_IDLE;
      case (state)
         IDLE:   TX_OUT = LINE_IDLE;
         START:  TX_OUT = LINE_START;
         DATA:   TX_OUT = Ser_Data;
`ifdef UART_TX_PARITY_EN
         PARITY: TX_OUT = parity_bit;
`endif
         STOP:   TX_OUT = LINE_STOP;
         default: TX_OUT = LINE_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Randomized self-checking bench for uart_tx_fsm with a shift-register serializer attached.
module tb_uart_tx_fsm;

   localparam int DW = 8;

   logic          CLK = 1'b0;
   logic          RST;
   logic [DW-1:0] P_DATA;
   logic          Data_Valid;
   logic          PAR_EN;
   logic          PAR_TYP;
   logic          Ser_Data;
   logic          Ser_En;
   logic          Ser_Send;
   logic          TX_OUT;
   logic          Busy;

   int checks = 0;
   int errors = 0;
   bit exp_q[$];

   always #5 CLK = ~CLK;

   uart_tx_fsm #(.DATA_WIDTH(DW)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .Ser_Data   (Ser_Data),
      .Ser_En     (Ser_En),
      .Ser_Send   (Ser_Send),
      .TX_OUT     (TX_OUT),
      .Busy       (Busy)
   );

   // Serializer: load on Ser_En, registered LSB-first output on Ser_Send.
   logic [DW-1:0] ser_sh;
   logic          ser_out;
   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         ser_sh  <= '0;
         ser_out <= 1'b1;
      end else if (Ser_En) begin
         ser_sh <= P_DATA;
      end else if (Ser_Send) begin
         ser_out <= ser_sh[0];
         ser_sh  <= ser_sh >> 1;
      end
   end
   assign Ser_Data = ser_out;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected line sequence of one frame: start, data LSB first, optional parity, stop.
   function automatic void build_frame(input logic [DW-1:0] d, input logic pe, input logic pt);
      bit par_on;
      exp_q.delete();
`ifdef UART_TX_PARITY_EN
      par_on = pe;
`else
      par_on = 1'b0;
`endif
      exp_q.push_back(1'b0);
      for (int k = 0; k < DW; k++) exp_q.push_back(d[k]);
      if (par_on) exp_q.push_back(bit'(($countones(d) % 2) != 0) ^ pt);
      exp_q.push_back(1'b1);
   endfunction

   task automatic check_idle(input string tag);
      check_val({tag, "_tx"},   TX_OUT,   1);
      check_val({tag, "_busy"}, Busy,     0);
      check_val({tag, "_en"},   Ser_En,   0);
      check_val({tag, "_send"}, Ser_Send, 0);
   endtask

   // Called just after a rising edge. poke_at / rst_at index the frame cycle (-1 = never).
   task automatic run_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                            input int poke_at, input int rst_at);
      int sends;
      P_DATA     = d;
      PAR_EN     = pe;
      PAR_TYP    = pt;
      Data_Valid = 1'b1;
      @(negedge CLK);
      check_val("req_en",   Ser_En, 1);
      check_val("req_tx",   TX_OUT, 1);
      check_val("req_busy", Busy,   0);
      @(posedge CLK); #1;
      Data_Valid = 1'b0;
      P_DATA     = DW'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 1'($urandom);
      build_frame(d, pe, pt);
      sends = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge CLK);
         check_val("tx_bit",    TX_OUT, exp_q[i]);
         check_val("busy_frm",  Busy,   1);
         check_val("en_frm",    Ser_En, 0);
         if (Ser_Send) sends++;
         if (i == rst_at) begin
            #2 RST = 1'b1;
            Data_Valid = 1'b1;
            #1;
            check_idle("rst_mid");
            @(posedge CLK); #1;
            check_idle("rst_hold");
            RST = 1'b0;
            Data_Valid = 1'b0;
            return;
         end
         if (i == poke_at) begin
            Data_Valid = 1'b1;
            P_DATA     = '1;
         end
         @(posedge CLK); #1;
         Data_Valid = 1'b0;
      end
      @(negedge CLK);
      check_idle("post_frm");
      check_val("send_cnt", sends, DW);
      @(posedge CLK); #1;
   endtask

   initial begin
      RST        = 1'b1;
      Data_Valid = 1'b0;
      P_DATA     = '0;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      #1;
      check_idle("in_rst");
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;

      for (int c = 0; c < 5; c++) begin
         @(negedge CLK);
         check_idle("idle5");
      end
      @(posedge CLK); #1;

      run_frame(8'hA5, 1'b1, 1'b0, -1, -1);
      run_frame(8'h01, 1'b1, 1'b1, -1, -1);
      run_frame(8'h01, 1'b0, 1'b0, -1, -1);
      run_frame(8'h5A, 1'b1, 1'b0, 3, -1);
      run_frame(8'hC3, 1'b0, 1'b1, 5, -1);
      // Reset during data bit 3, then a request on the first edge after release.
      run_frame(8'hF0, 1'b1, 1'b1, -1, 4);
      run_frame(8'h3C, 1'b1, 1'b0, -1, -1);

      for (int n = 0; n < 25; n++) begin
         int gap;
         run_frame(DW'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DW)) : -1, -1);
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            @(negedge CLK);
            check_idle("gap");
            @(posedge CLK); #1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
